// File: rtl/tpu_dispatch_pkg.sv
// rtl/tpu_dispatch_pkg.sv - shared state type and systolic-interface limits for matmul_dispatcher
package tpu_dispatch_pkg;

  localparam int SYS_ROWS_W   = 8;
  localparam int MAX_SYS_ROWS = 255;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2,
    D_RESP  = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/dispatch_watchdog.sv
// rtl/dispatch_watchdog.sv - tile-completion watchdog, present only when DISPATCH_WATCHDOG_EN is defined
`ifdef DISPATCH_WATCHDOG_EN
module dispatch_watchdog #(
  parameter int WDOG_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Expiry fires on the WDOG_CYCLES-th enabled cycle after a clear.
  assign o_expired = i_enable && (r_cnt == CNT_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/matmul_dispatcher.sv
// rtl/matmul_dispatcher.sv - splits matmul commands into tiles for the systolic controller
// Optional tile watchdog enabled by DISPATCH_WATCHDOG_EN.
module matmul_dispatcher
  import tpu_dispatch_pkg::*;
#(
  parameter int ROWS_W        = 16,
  parameter int TAG_W         = 4,
  parameter int MAX_TILE_ROWS = 255,
  parameter int WDOG_CYCLES   = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ROWS_W-1:0]     i_cmd_rows,
  input  logic [TAG_W-1:0]      i_cmd_tag,
  output logic                  o_sys_start,
  output logic [SYS_ROWS_W-1:0] o_sys_rows,
  input  logic                  i_sys_busy,
  input  logic                  i_sys_done,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [TAG_W-1:0]      o_rsp_tag,
  output logic [ROWS_W-1:0]     o_rsp_tiles,
  output logic                  o_rsp_err,
  output logic                  o_dispatch_busy
);

  localparam int TILE_MAX = (MAX_TILE_ROWS > MAX_SYS_ROWS) ? MAX_SYS_ROWS : MAX_TILE_ROWS;

  dispatch_state_t       r_state;
  dispatch_state_t       w_next;
  logic [TAG_W-1:0]      r_tag;
  logic [ROWS_W-1:0]     r_remaining;
  logic [ROWS_W-1:0]     r_tiles;
  logic                  r_err;
  logic [SYS_ROWS_W-1:0] r_sys_rows;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_expired;
  logic [ROWS_W-1:0]     w_tile_src;
  logic [SYS_ROWS_W-1:0] w_tile_rows;

  assign w_accept = (r_state == D_IDLE) && i_cmd_valid;
  assign w_start  = (r_state == D_ISSUE) && !i_sys_busy;

  // Next tile size comes from the new command on accept, otherwise from what is left.
  assign w_tile_src  = (r_state == D_IDLE) ? i_cmd_rows : r_remaining;
  assign w_tile_rows = (w_tile_src > ROWS_W'(TILE_MAX)) ? SYS_ROWS_W'(TILE_MAX)
                                                        : w_tile_src[SYS_ROWS_W-1:0];

`ifdef DISPATCH_WATCHDOG_EN
  dispatch_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_start),
    .i_enable (r_state == D_WAIT),
    .o_expired(w_expired)
  );
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES != 0);
  assign w_expired     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= D_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      D_IDLE:  if (i_cmd_valid) w_next = (i_cmd_rows == '0) ? D_RESP : D_ISSUE;
      D_ISSUE: if (w_start) w_next = D_WAIT;
      D_WAIT: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (i_sys_done) begin
          w_next = (r_remaining == '0) ? D_RESP : D_ISSUE;
        end else if (w_expired) begin
          w_next = D_RESP;
        end
      end
      D_RESP:  if (i_rsp_ready) w_next = D_IDLE;
      default: w_next = D_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready     = (r_state == D_IDLE);
    o_rsp_valid     = (r_state == D_RESP);
    o_sys_start     = w_start;
    o_dispatch_busy = (r_state != D_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag       <= '0;
      r_remaining <= '0;
      r_tiles     <= '0;
      r_err       <= 1'b0;
      r_sys_rows  <= '0;
    end else begin
      if (w_accept) begin
        r_tag       <= i_cmd_tag;
        r_remaining <= i_cmd_rows;
        r_tiles     <= '0;
        r_err       <= 1'b0;
      end
      if (w_start) begin
        r_remaining <= r_remaining - ROWS_W'(r_sys_rows);
        r_tiles     <= r_tiles + ROWS_W'(1);
      end
      if ((r_state == D_WAIT) && !i_sys_done && w_expired) begin
        r_err <= 1'b1;
      end
      if ((w_next == D_ISSUE) && (r_state != D_ISSUE)) begin
        r_sys_rows <= w_tile_rows;
      end
    end
  end

  assign o_sys_rows  = r_sys_rows;
  assign o_rsp_tag   = r_tag;
  assign o_rsp_tiles = r_tiles;
  assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_matmul_dispatcher.sv
// tb/tb_matmul_dispatcher.sv - self-checking bench for matmul_dispatcher (with or without DISPATCH_WATCHDOG_EN)
module tb_matmul_dispatcher;

  localparam int MAXT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, dispatch_busy;
  logic [15:0] cmd_rows, rsp_tiles;
  logic [3:0]  cmd_tag, rsp_tag;
  logic        sys_start, sys_busy, sys_done;
  logic [7:0]  sys_rows;

  logic        wd_cmd_valid, wd_cmd_ready, wd_rsp_valid, wd_rsp_ready, wd_rsp_err, wd_dispatch_busy;
  logic [15:0] wd_cmd_rows, wd_rsp_tiles;
  logic [3:0]  wd_cmd_tag, wd_rsp_tag;
  logic        wd_sys_start, wd_sys_busy, wd_sys_done;
  logic [7:0]  wd_sys_rows;

  logic        m_busy, m_done, force_busy, no_done, inj_done;
  int          m_cnt;

  matmul_dispatcher #(.ROWS_W(16), .TAG_W(4), .MAX_TILE_ROWS(MAXT), .WDOG_CYCLES(1023)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rows(cmd_rows), .i_cmd_tag(cmd_tag),
    .o_sys_start(sys_start), .o_sys_rows(sys_rows), .i_sys_busy(sys_busy), .i_sys_done(sys_done),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_tag(rsp_tag), .o_rsp_tiles(rsp_tiles),
    .o_rsp_err(rsp_err), .o_dispatch_busy(dispatch_busy)
  );

  // Second instance with a short watchdog and a controller that never completes.
  matmul_dispatcher #(.ROWS_W(16), .TAG_W(4), .MAX_TILE_ROWS(MAXT), .WDOG_CYCLES(16)) u_wd (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(wd_cmd_valid), .o_cmd_ready(wd_cmd_ready), .i_cmd_rows(wd_cmd_rows), .i_cmd_tag(wd_cmd_tag),
    .o_sys_start(wd_sys_start), .o_sys_rows(wd_sys_rows), .i_sys_busy(wd_sys_busy), .i_sys_done(wd_sys_done),
    .o_rsp_valid(wd_rsp_valid), .i_rsp_ready(wd_rsp_ready), .o_rsp_tag(wd_rsp_tag), .o_rsp_tiles(wd_rsp_tiles),
    .o_rsp_err(wd_rsp_err), .o_dispatch_busy(wd_dispatch_busy)
  );

  // Systolic controller model: busy after start, done pulse rows+6 cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (sys_start) begin
        m_busy <= 1'b1;
        m_cnt  <= int'(sys_rows) + 6;
      end else if (m_busy && !no_done) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end
  assign sys_busy = m_busy | force_busy;
  assign sys_done = m_done | inj_done;

  typedef struct { int rows; int tag; int tiles; int last; } vec_t;
  typedef struct { int tag; int tiles; int err; } rsp_t;

  vec_t vecs[7];
  rsp_t rsp_q[$];
  rsp_t mon_e;
  int   tile_q[$];
  int   n_checks = 0, n_pass = 0, n_starts = 0, n_rsp = 0, target = 0;
  int   s0, w, saw;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && sys_start) begin
      n_starts++;
      if (tile_q.size() == 0) check("start_expected", tile_q.size(), 1);
      else check("sys_rows", int'(sys_rows), tile_q.pop_front());
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        check("rsp_expected", rsp_q.size(), 1);
      end else begin
        mon_e = rsp_q.pop_front();
        check("rsp_tag", int'(rsp_tag), mon_e.tag);
        check("rsp_tiles", int'(rsp_tiles), mon_e.tiles);
        check("rsp_err", int'(rsp_err), mon_e.err);
      end
      n_rsp++;
    end
  end

  task automatic send_cmd(input int rows, input int tag);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_rows  = 16'(rows);
    cmd_tag   = 4'(tag);
    while (!cmd_ready && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_accept_in_time", int'(t < 2000), 1);
  endtask

  task automatic wait_rsp(input int tgt, input int budget);
    int t = 0;
    while (n_rsp < tgt && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("rsp_in_time", int'(n_rsp >= tgt), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d responses, want %0d", n_rsp, target);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 0; cmd_rows = 0; cmd_tag = 0; rsp_ready = 1;
    force_busy = 0; no_done = 0; inj_done = 0;
    wd_cmd_valid = 0; wd_cmd_rows = 0; wd_cmd_tag = 0; wd_rsp_ready = 0;
    wd_sys_busy = 0; wd_sys_done = 0;

    vecs[0] = '{10, 3, 1, 10};
    vecs[1] = '{600, 5, 3, 90};
    vecs[2] = '{255, 1, 1, 255};
    vecs[3] = '{256, 2, 2, 1};
    vecs[4] = '{510, 9, 2, 255};
    vecs[5] = '{1, 15, 1, 1};
    vecs[6] = '{0, 7, 0, 0};

    @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_sys_start", int'(sys_start), 0);
    check("rst_sys_rows", int'(sys_rows), 0);
    check("rst_busy", int'(dispatch_busy), 0);
    check("rst_rsp_fields", int'({rsp_tag, rsp_tiles, rsp_err}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Stray completion while idle must be ignored.
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    @(negedge clk);
    check("idle_done_busy", int'(dispatch_busy), 0);
    check("idle_done_rsp", int'(rsp_valid), 0);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < vecs[i].tiles; k++)
        tile_q.push_back((k == vecs[i].tiles - 1) ? vecs[i].last : MAXT);
      rsp_q.push_back('{vecs[i].tag, vecs[i].tiles, 0});
      s0 = n_starts;
      target++;
      send_cmd(vecs[i].rows, vecs[i].tag);
      wait_rsp(target, 3000);
      check("start_count", n_starts - s0, vecs[i].tiles);
    end

    // Zero-row latency, then response backpressure with a second command waiting.
    rsp_q.push_back('{7, 0, 0});
    rsp_q.push_back('{11, 2, 0});
    tile_q.push_back(255);
    tile_q.push_back(45);
    target += 2;
    @(posedge clk); #1;
    rsp_ready = 0; cmd_valid = 1; cmd_rows = 0; cmd_tag = 7;
    @(negedge clk);
    check("z_cmd_ready", int'(cmd_ready), 1);
    check("z_rsp_pre", int'(rsp_valid), 0);
    @(posedge clk); #1;
    cmd_rows = 300; cmd_tag = 11;
    @(negedge clk);
    check("z_rsp_valid_t1", int'(rsp_valid), 1);
    check("z_rsp_tag", int'(rsp_tag), 7);
    check("z_rsp_tiles", int'(rsp_tiles), 0);
    check("z_no_start", int'(sys_start), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_rsp_valid", int'(rsp_valid), 1);
      check("hold_rsp_fields", int'({rsp_tag, rsp_tiles}), int'({4'd7, 16'd0}));
      check("hold_cmd_ready", int'(cmd_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(posedge clk); #1;
    check("ready_after_hs", int'(cmd_ready), 1);
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk);
    check("second_start_t1", int'(sys_start), 1);
    check("second_cmd_ready", int'(cmd_ready), 0);
    wait_rsp(target, 3000);

    // Busy held high at issue entry stalls the start pulse.
    force_busy = 1;
    tile_q.push_back(20);
    rsp_q.push_back('{4, 1, 0});
    target++;
    send_cmd(20, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_no_start", int'(sys_start), 0);
      check("busy_dispatch", int'(dispatch_busy), 1);
      @(posedge clk); #1;
    end
    force_busy = 0;
    @(negedge clk);
    check("busy_drop_start", int'(sys_start), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_pulse", int'(sys_start), 0);
    wait_rsp(target, 3000);

    // Main instance left hanging so the reset pulse must drop it.
    no_done = 1;
    tile_q.push_back(50);
    send_cmd(50, 2);

    @(posedge clk); #1;
    wd_cmd_valid = 1; wd_cmd_rows = 600; wd_cmd_tag = 6;
    @(negedge clk);
    check("wd_cmd_ready", int'(wd_cmd_ready), 1);
    @(posedge clk); #1 wd_cmd_valid = 0;
    @(negedge clk);
    check("wd_start", int'(wd_sys_start), 1);
    check("wd_sys_rows", int'(wd_sys_rows), 255);
`ifdef DISPATCH_WATCHDOG_EN
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!wd_rsp_valid && w < 200);
    check("wd_latency", w, 17);
    check("wd_rsp_tag", int'(wd_rsp_tag), 6);
    check("wd_rsp_tiles", int'(wd_rsp_tiles), 1);
    check("wd_rsp_err", int'(wd_rsp_err), 1);
    @(posedge clk); #1 wd_rsp_ready = 1;
    @(posedge clk); #1 wd_rsp_ready = 0;
    @(negedge clk);
    check("wd_idle_after_rsp", int'(wd_cmd_ready), 1);
`else
    repeat (100) @(negedge clk);
    check("wd_still_busy", int'(wd_dispatch_busy), 1);
    check("wd_no_rsp", int'(wd_rsp_valid), 0);
    check("wd_not_ready", int'(wd_cmd_ready), 0);
`endif

    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    check("mid_rst_start", int'(sys_start), 0);
    check("mid_rst_busy", int'(dispatch_busy), 0);
    check("mid_rst_wd_ready", int'(wd_cmd_ready), 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_done = 0;
    wd_rsp_ready = 1;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || wd_rsp_valid) saw++;
    end
    check("no_rsp_after_rst", saw, 0);
    check("post_rst_ready", int'(cmd_ready), 1);

    tile_q.push_back(10);
    rsp_q.push_back('{12, 1, 0});
    target++;
    send_cmd(10, 12);
    wait_rsp(target, 3000);

    check("tile_q_drained", tile_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
